// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (instruction fetch / data) arbiter in front of a single
//            memory port. One outstanding transaction at a time, with a wait
//            counter that terminates a stalled transaction with an error.
// Options  : MEM_ARBITER_RR_EN - when defined, simultaneous requests alternate
//            between the ports (round-robin). When undefined, the data port
//            wins simultaneous requests.
// Ports    :
//   clk, reset             clock (rising edge), synchronous active-high reset
//   i_req/i_addr           fetch request (held until i_ack), fetch address
//   i_ack/i_rdata          fetch completion pulse and data (0 when no ack)
//   d_req/d_writeb         data request (held until d_ack), byte enables
//   d_addr/d_wdata         data address and write data
//   d_ack/d_rdata          data completion pulse and load data (0 when no ack)
//   err                    pulses with the owner ack when the access timed out
//   m_req                  memory request, held until m_ack
//   m_addr/m_writeb/m_wdata registered request attributes, held until done
//   m_ack/m_rvalid/m_rdata memory accept, read-data valid, read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    // data port
    input  logic              d_req,
    input  logic [3:0]        d_writeb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    // shared error flag
    output logic              err,
    // memory port
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_writeb,
    output logic [31:0]       m_wdata,
    input  logic              m_ack,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata
);

    // The counter holds the number of wait cycles already elapsed; the
    // transaction is cut off in its TIMEOUT-th wait cycle.
    localparam int               c_cnt_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner_d;     // 1 = data port owns the transaction
    logic                r_m_req;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [3:0]          r_m_writeb;
    logic [31:0]         r_m_wdata;
    logic [c_cnt_w-1:0]  r_cnt;
`ifdef MEM_ARBITER_RR_EN
    logic                r_last_d;      // 1 = data port received the last grant
`endif

    logic                w_is_write;
    logic                w_timeout;
    logic                w_done;
    logic                w_err;
    logic [31:0]         w_rdata;
    logic                w_grant_d;

    assign w_is_write = (r_m_writeb != 4'd0);
    assign w_timeout  = (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------------
    // Completion decode. A genuine memory completion wins over a timeout that
    // falls in the same cycle. Nothing completes while reset is asserted so an
    // abandoned transaction never produces an ack.
    // ------------------------------------------------------------------------
    always_comb begin
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_rdata = 32'd0;
        if (!reset) begin
            unique case (r_state)
                WAIT_ACK: begin
                    if (m_ack && w_is_write) begin
                        w_done = 1'b1;
                    end else if (m_ack && m_rvalid) begin
                        w_done  = 1'b1;
                        w_rdata = m_rdata;
                    end else if (w_timeout) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (m_rvalid) begin
                        w_done  = 1'b1;
                        w_rdata = m_rdata;
                    end else if (w_timeout) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end
                end
                default: begin
                    w_done = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Owner selection for an IDLE cycle. A lone request always wins; only the
    // tie-break between simultaneous requests depends on the build option.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant_d = d_req;
`ifdef MEM_ARBITER_RR_EN
        if (i_req && d_req) begin
            w_grant_d = ~r_last_d;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Transaction FSM. Grants are only issued from IDLE and every completion
    // returns to IDLE, which guarantees one idle cycle between transactions.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner_d  <= 1'b0;
            r_m_req    <= 1'b0;
            r_m_addr   <= '0;
            r_m_writeb <= 4'd0;
            r_m_wdata  <= 32'd0;
            r_cnt      <= '0;
`ifdef MEM_ARBITER_RR_EN
            r_last_d   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_req || d_req) begin
                        r_state   <= WAIT_ACK;
                        r_m_req   <= 1'b1;
                        r_owner_d <= w_grant_d;
                        r_cnt     <= '0;
                        if (w_grant_d) begin
                            r_m_addr   <= d_addr;
                            r_m_writeb <= d_writeb;
                            r_m_wdata  <= d_wdata;
                        end else begin
                            // fetches are always reads
                            r_m_addr   <= i_addr;
                            r_m_writeb <= 4'd0;
                            r_m_wdata  <= 32'd0;
                        end
`ifdef MEM_ARBITER_RR_EN
                        r_last_d <= w_grant_d;
`endif
                    end
                end
                WAIT_ACK: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_m_req <= 1'b0;
                    end else if (m_ack) begin
                        // read accepted, data still to come
                        r_state <= WAIT_DATA;
                        r_m_req <= 1'b0;
                        r_cnt   <= r_cnt + c_cnt_one;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                WAIT_DATA: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_m_req <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Acks are steered only to the registered owner, so both can
    // never be high together; read data is forced to zero without an ack.
    // ------------------------------------------------------------------------
    assign i_ack    = w_done & ~r_owner_d;
    assign d_ack    = w_done &  r_owner_d;
    assign err      = w_done &  w_err;
    assign i_rdata  = i_ack ? w_rdata : 32'd0;
    assign d_rdata  = d_ack ? w_rdata : 32'd0;

    assign m_req    = r_m_req;
    assign m_addr   = r_m_addr;
    assign m_writeb = r_m_writeb;
    assign m_wdata  = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A memory responder with
//            programmable accept / read-data delays drives the memory port;
//            expected owner, timing and data come from a rule-level model.
// Options  : MEM_ARBITER_RR_EN selects the round-robin tie-break model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic [3:0]        d_writeb;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              err;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_writeb;
    logic [31:0]       m_wdata;
    logic              m_ack;
    logic              m_rvalid;
    logic [31:0]       m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_writeb(d_writeb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .m_req(m_req), .m_addr(m_addr), .m_writeb(m_writeb), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    int checks   = 0;
    int failures = 0;

    // model state: which port received the most recent grant (1 = data)
    logic model_last_d;

    // observations of the most recent transaction
    int          ob_s, ob_done, ob_reqcyc;
    logic        ob_own_d, ob_err, ob_none, ob_both, ob_leak, ob_unstable;
    logic        ob_mreq_after, ob_ack_after;
    logic [31:0] ob_rdata, ob_addr, ob_wd;
    logic [3:0]  ob_wb;

    // Owner of the next grant from the arbitration rules.
    function automatic logic model_owner(input logic iq, input logic dq);
`ifdef MEM_ARBITER_RR_EN
        if (iq && dq) return !model_last_d;
`endif
        return dq;
    endfunction

    // Completion cycle (relative to first m_req cycle), error flag and number
    // of cycles m_req stays high, from the memory delays and the timeout rule.
    function automatic void model_timing(input int a, input int r, input logic wr,
                                         output int done, output logic e, output int rq);
        int normal;
        if (wr) normal = a;
        else    normal = (a >= 0 && r >= 0) ? ((r > a) ? r : a) : -1;
        if (normal >= 0 && normal <= TMO - 1) begin
            done = normal; e = 1'b0;
        end else begin
            done = TMO - 1; e = 1'b1;
        end
        rq = (a >= 0 && a <= done) ? a + 1 : done + 1;
    endfunction

    // Memory responder + monitor for one transaction. Starts in an IDLE cycle
    // with the requests already driven; returns in the idle cycle after done.
    task automatic run_txn(input int ack_dly, input int rv_dly,
                           input logic [31:0] rv_val, input logic keep);
        int  n;
        logic hit_rv;
        ob_s = -1; ob_done = -1; ob_reqcyc = 0; ob_both = 0; ob_leak = 0;
        ob_unstable = 0; ob_err = 0; ob_none = 0; ob_own_d = 0; ob_rdata = 0;
        n = 0;
        while (ob_done < 0 && n < 40) begin
            if (ob_s < 0 && m_req) ob_s = n;
            hit_rv = (ob_s >= 0 && rv_dly >= 0 && (n - ob_s) == rv_dly);
            if (ob_s >= 0) begin
                m_ack    = (ack_dly >= 0 && (n - ob_s) == ack_dly);
                m_rvalid = hit_rv;
            end else begin
                // stray strobes while idle must be ignored
                m_ack    = 1'($urandom_range(0, 1));
                m_rvalid = 1'($urandom_range(0, 1));
            end
            m_rdata = hit_rv ? rv_val : $urandom;
            if (!i_req) i_addr = $urandom;
            if (!d_req) begin
                d_addr = $urandom; d_wdata = $urandom; d_writeb = 4'($urandom);
            end
            @(negedge clk);
            if (m_req) ob_reqcyc++;
            if (i_ack && d_ack) ob_both = 1;
            if ((!i_ack && i_rdata != 0) || (!d_ack && d_rdata != 0)) ob_leak = 1;
            if (ob_s >= 0 && n == ob_s) begin
                ob_addr = m_addr; ob_wb = m_writeb; ob_wd = m_wdata;
            end else if (ob_s >= 0) begin
                if (m_addr !== ob_addr || m_writeb !== ob_wb || m_wdata !== ob_wd)
                    ob_unstable = 1;
            end
            if (i_ack || d_ack || err) begin
                ob_done  = n;
                ob_own_d = d_ack;
                ob_err   = err;
                ob_none  = !(i_ack || d_ack);
                ob_rdata = d_ack ? d_rdata : i_rdata;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (ob_done < 0) begin
            checks++; failures++;
            $display("FAIL txn_budget: transaction did not complete within 40 cycles");
        end
        @(posedge clk); #1;
        m_ack = 1'b0; m_rvalid = 1'b0;
        if (ob_done < 0) begin
            i_req = 1'b0; d_req = 1'b0;
        end else if (!keep) begin
            if (ob_own_d) d_req = 1'b0;
            else          i_req = 1'b0;
        end
        #1;
        ob_mreq_after = m_req;
        ob_ack_after  = i_ack | d_ack | err;
    endtask

    task automatic apply_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; m_rvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        model_last_d = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
        d_wdata = '0; d_writeb = '0; m_ack = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req: got %b want 0", m_req); end
        checks++; if (m_addr !== '0) begin failures++; $display("FAIL reset_m_addr: got %h want 0", m_addr); end
        checks++; if ({m_writeb, m_wdata} !== 36'd0) begin failures++; $display("FAIL reset_m_wb_wd: got %h/%h want 0/0", m_writeb, m_wdata); end
        checks++; if ({i_ack, d_ack, err} !== 3'b000) begin failures++; $display("FAIL reset_acks: got %b want 000", {i_ack, d_ack, err}); end
        checks++; if ((i_rdata | d_rdata) !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h/%h want 0", i_rdata, d_rdata); end
        @(posedge clk); #1;
        reset = 1'b0; m_ack = 1'b0; m_rvalid = 1'b0;
        model_last_d = 1'b0;
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL idle_no_req: got %b want 0", m_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 32'h0000_0100;
        run_txn(0, 2, 32'h0000_0013, 1'b0);
        model_last_d = 1'b0;
        checks++; if (ob_s !== 1) begin failures++; $display("FAIL fetch_grant_latency: m_req first at cycle %0d want 1", ob_s); end
        checks++; if (ob_own_d !== 1'b0 || ob_none || ob_err) begin failures++; $display("FAIL fetch_owner: d=%b none=%b err=%b want i_ack only", ob_own_d, ob_none, ob_err); end
        checks++; if (ob_rdata !== 32'h0000_0013) begin failures++; $display("FAIL fetch_rdata: got %h want 00000013", ob_rdata); end
        checks++; if (ob_done - ob_s !== 2) begin failures++; $display("FAIL fetch_done: got %0d want 2", ob_done - ob_s); end
        checks++; if (ob_addr !== 32'h100 || ob_wb !== 4'd0) begin failures++; $display("FAIL fetch_m_attr: got %h/%h want 00000100/0", ob_addr, ob_wb); end
        checks++; if (ob_reqcyc !== 1 || ob_mreq_after !== 1'b0) begin failures++; $display("FAIL fetch_m_req: cycles %0d after %b want 1/0", ob_reqcyc, ob_mreq_after); end
        checks++; if (ob_ack_after !== 1'b0) begin failures++; $display("FAIL fetch_ack_width: ack still %b next cycle want 0", ob_ack_after); end
    endtask

    task automatic test_store();
        d_req = 1'b1; d_writeb = 4'hF; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        run_txn(2, -1, 32'd0, 1'b0);
        model_last_d = 1'b1;
        checks++; if (ob_addr !== 32'h2000 || ob_wb !== 4'hF || ob_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_m_attr: got %h/%h/%h want 00002000/f/deadbeef", ob_addr, ob_wb, ob_wd); end
        checks++; if (ob_own_d !== 1'b1 || ob_none || ob_both || ob_err) begin failures++; $display("FAIL store_owner: d=%b none=%b both=%b err=%b want d_ack only", ob_own_d, ob_none, ob_both, ob_err); end
        checks++; if (ob_done - ob_s !== 2) begin failures++; $display("FAIL store_done: got %0d want 2", ob_done - ob_s); end
        checks++; if (ob_reqcyc !== 3 || ob_mreq_after !== 1'b0 || ob_unstable) begin failures++; $display("FAIL store_m_req: cycles %0d after %b unstable %b want 3/0/0", ob_reqcyc, ob_mreq_after, ob_unstable); end
    endtask

    task automatic test_simultaneous();
        logic e_own;
        int   a, r, e_done, e_rq;
        logic e_err;
        apply_reset();
        i_req = 1'b1; i_addr = 32'h0000_0300;
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_writeb = 4'h3;
        for (int k = 0; k < 4; k++) begin
            e_own = model_owner(i_req, d_req);
            a = int'($urandom_range(0, 2));
            r = a + int'($urandom_range(0, 2));
            model_timing(a, r, e_own && (d_writeb != 0), e_done, e_err, e_rq);
            run_txn(a, r, $urandom, 1'b1);
            model_last_d = e_own;
            checks++; if (ob_own_d !== e_own || ob_none || ob_both) begin failures++; $display("FAIL simul_owner[%0d]: d=%b none=%b both=%b want d=%b", k, ob_own_d, ob_none, ob_both, e_own); end
            checks++; if (ob_addr !== (e_own ? d_addr : i_addr) || ob_done - ob_s !== e_done) begin failures++; $display("FAIL simul_txn[%0d]: addr %h done %0d want %h/%0d", k, ob_addr, ob_done - ob_s, e_own ? d_addr : i_addr, e_done); end
            // the owner starts a new transaction straight away
            if (e_own) begin d_addr = $urandom; d_wdata = $urandom; d_writeb = 4'($urandom); end
            else       i_addr = $urandom;
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL simul_idle: m_req %b want 0", m_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_writeb = 4'd0; d_addr = $urandom;
        run_txn(-1, -1, 32'd0, 1'b0);
        model_last_d = 1'b1;
        checks++; if (ob_own_d !== 1'b1 || ob_err !== 1'b1 || ob_none) begin failures++; $display("FAIL tmo_ack_err: d=%b err=%b none=%b want 1/1/0", ob_own_d, ob_err, ob_none); end
        checks++; if (ob_done - ob_s !== TMO - 1 || ob_rdata !== 32'd0) begin failures++; $display("FAIL tmo_timing: done %0d rdata %h want %0d/0", ob_done - ob_s, ob_rdata, TMO - 1); end
        checks++; if (ob_reqcyc !== TMO || ob_mreq_after !== 1'b0) begin failures++; $display("FAIL tmo_m_req: cycles %0d after %b want %0d/0", ob_reqcyc, ob_mreq_after, TMO); end
        // accepted read whose data never arrives
        i_req = 1'b1; i_addr = $urandom;
        run_txn(0, -1, 32'd0, 1'b0);
        model_last_d = 1'b0;
        checks++; if (ob_own_d !== 1'b0 || ob_err !== 1'b1 || ob_none || ob_rdata !== 32'd0) begin failures++; $display("FAIL tmo_data: d=%b err=%b none=%b rdata %h want 0/1/0/0", ob_own_d, ob_err, ob_none, ob_rdata); end
        checks++; if (ob_done - ob_s !== TMO - 1 || ob_reqcyc !== 1) begin failures++; $display("FAIL tmo_data_timing: done %0d cycles %0d want %0d/1", ob_done - ob_s, ob_reqcyc, TMO - 1); end
    endtask

    task automatic test_reset_mid();
        int   w;
        logic seen_ack;
        i_req = 1'b1; i_addr = $urandom;
        w = 0;
        while (!m_req && w < 10) begin @(posedge clk); #1; w++; end
        checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL rmid_grant: m_req %b want 1", m_req); end
        m_ack = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; i_req = 1'b0;
        seen_ack = 1'b0;
        @(negedge clk);
        if (i_ack || d_ack || err) seen_ack = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_last_d = 1'b0;
        @(negedge clk);
        if (i_ack || d_ack || err) seen_ack = 1'b1;
        checks++; if ({m_req, m_writeb} !== 5'd0 || m_addr !== '0 || m_wdata !== 32'd0) begin failures++; $display("FAIL rmid_outputs: %b/%h/%h/%h want all 0", m_req, m_addr, m_writeb, m_wdata); end
        @(posedge clk); #1;
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        if (i_ack || d_ack || err || i_rdata != 0) seen_ack = 1'b1;
        checks++; if (seen_ack !== 1'b0 || m_req !== 1'b0) begin failures++; $display("FAIL rmid_no_ack: ack seen %b m_req %b want 0/0", seen_ack, m_req); end
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0440;
        run_txn(1, 1, 32'h1234_5678, 1'b0);
        model_last_d = 1'b0;
        checks++; if (ob_own_d !== 1'b0 || ob_none || ob_err || ob_rdata !== 32'h1234_5678 || ob_addr !== 32'h440 || ob_s !== 1) begin failures++; $display("FAIL rmid_next: d=%b err=%b rdata %h addr %h s %0d want 0/0/12345678/440/1", ob_own_d, ob_err, ob_rdata, ob_addr, ob_s); end
    endtask

    task automatic test_random();
        int          a, r, e_done, e_rq;
        logic        e_err, e_own, wr;
        logic [31:0] e_addr, e_wd, rv_val;
        logic [3:0]  e_wb;
        for (int it = 0; it < 40; it++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin i_req = 1'b1; i_addr = $urandom; end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                d_writeb = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
            end
            if (!i_req && !d_req) begin i_req = 1'b1; i_addr = $urandom; end
            e_own  = model_owner(i_req, d_req);
            wr     = e_own && (d_writeb != 4'd0);
            e_addr = e_own ? d_addr : i_addr;
            e_wb   = e_own ? d_writeb : 4'd0;
            e_wd   = d_wdata;
            a = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            if (wr || a < 0 || $urandom_range(0, 7) == 0) r = -1;
            else r = a + int'($urandom_range(0, 3));
            model_timing(a, r, wr, e_done, e_err, e_rq);
            rv_val = $urandom;
            run_txn(a, r, rv_val, 1'b0);
            model_last_d = e_own;
            checks++; if (ob_s !== 1 || ob_own_d !== e_own || ob_none || ob_both) begin failures++; $display("FAIL rnd_owner[%0d]: s %0d d=%b none=%b both=%b want 1/%b/0/0", it, ob_s, ob_own_d, ob_none, ob_both, e_own); end
            checks++; if (ob_done - ob_s !== e_done || ob_err !== e_err) begin failures++; $display("FAIL rnd_timing[%0d]: done %0d err %b want %0d/%b (a=%0d r=%0d)", it, ob_done - ob_s, ob_err, e_done, e_err, a, r); end
            checks++; if (ob_addr !== e_addr || ob_wb !== e_wb || (e_own && ob_wd !== e_wd) || ob_unstable) begin failures++; $display("FAIL rnd_m_attr[%0d]: %h/%h/%h unstable %b want %h/%h/%h", it, ob_addr, ob_wb, ob_wd, ob_unstable, e_addr, e_wb, e_wd); end
            if (!wr) begin
                checks++; if (ob_rdata !== (e_err ? 32'd0 : rv_val)) begin failures++; $display("FAIL rnd_rdata[%0d]: got %h want %h", it, ob_rdata, e_err ? 32'd0 : rv_val); end
            end
            checks++; if (ob_reqcyc !== e_rq || ob_mreq_after !== 1'b0 || ob_ack_after !== 1'b0 || ob_leak) begin failures++; $display("FAIL rnd_handshake[%0d]: req cycles %0d after %b ack_after %b leak %b want %0d/0/0/0", it, ob_reqcyc, ob_mreq_after, ob_ack_after, ob_leak, e_rq); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
